// File: rtl/sdm_pkg.sv
// Shared definitions for the serial frame demultiplexer.
// Holds the frame-walker state encoding and the width helpers used to size
// the port field and the bit counter.
package sdm_pkg;

  localparam int SDM_STATE_W = 3;

  typedef enum logic [SDM_STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PORT = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAR  = 3'd4
  } sdm_state_e;

  // Number of bits needed to encode values 0..value-1 (0 for value <= 1).
  function automatic int sdm_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int sdm_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_field_shifter.sv
// MSB-first field capture register.
// Bits enter through bit_i on shift_en_i; on load_en_i the completed field
// (including the bit presented on that same edge) is copied to data_o and
// held there while the next field is shifted in.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   shift_en_i  : accept bit_i into the shift chain
//   load_en_i   : copy the field value after this shift into data_o
//   bit_i       : serial input bit
//   next_o      : field value including bit_i (combinational)
//   data_o      : held field value
module serial_field_shifter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en_i,
  input  logic         load_en_i,
  input  logic         bit_i,
  output logic [W-1:0] next_o,
  output logic [W-1:0] data_o
);

  logic [W-1:0] hold_q;

  // Only the W-1 earlier bits need storage; the last bit of a field comes
  // straight from bit_i on the load edge.
  generate
    if (W == 1) begin : g_single
      assign next_o = bit_i;
    end else begin : g_multi
      logic [W-2:0] shift_q;

      assign next_o = {shift_q, bit_i};

      always_ff @(posedge clk) begin
        if (rst) begin
          shift_q <= '0;
        end else if (shift_en_i) begin
          shift_q <= next_o[W-2:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (load_en_i) begin
      hold_q <= next_o;
    end
  end

  assign data_o = hold_q;

endmodule

// File: rtl/serial_demux_ctrl_p.sv
// Serial frame controller: waits for a start bit on an idle-high line,
// captures a port field and a length field (both MSB first), then forwards
// the payload bits to one of NUM_CH channels, optionally followed by one
// even-parity bit.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (overrides clk_en)
//   clk_en         : bit strobe; everything except pulse clearing advances on it
//   ser_in         : serial line, idle high
//   ser_out        : registered copy of the last payload bit
//   ser_out_valid  : one-hot per-channel qualifier, one clk per payload bit
//   port_q, len_q  : captured fields, held until the next frame replaces them
//   busy           : high whenever a frame is being received
//   done           : one-clk pulse after the final frame bit
//   port_err       : with done, when the port field names no channel
//   parity_err     : with done, when the even parity check fails
// Handshake: there is no back-pressure. Each payload bit is offered exactly
// once, as a single-clk pulse on ser_out_valid[port_q] with ser_out holding
// the bit; a consumer must take it in that cycle.
module serial_demux_ctrl_p
  import sdm_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  LEN_W     = 4,
  parameter bit  PARITY_EN = 1'b0,
  localparam int PORT_W    = sdm_max(1, sdm_clog2(NUM_CH))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              ser_in,
  output logic              ser_out,
  output logic [NUM_CH-1:0] ser_out_valid,
  output logic [PORT_W-1:0] port_q,
  output logic [LEN_W-1:0]  len_q,
  output logic              busy,
  output logic              done,
  output logic              port_err,
  output logic              parity_err
);

  localparam int CNT_W = sdm_clog2(sdm_max(sdm_max(PORT_W, LEN_W), (1 << LEN_W) - 1) + 1);
  localparam logic [CNT_W-1:0]  PORT_LAST  = CNT_W'(PORT_W - 1);
  localparam logic [CNT_W-1:0]  LEN_LAST   = CNT_W'(LEN_W - 1);
  localparam logic [PORT_W:0]   NUM_CH_EXT = (PORT_W + 1)'(NUM_CH);

  sdm_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  len_ext;
  logic              data_last;
  logic [PORT_W-1:0] port_next;
  logic [LEN_W-1:0]  len_next;

  // Per-edge strobes, already qualified by clk_en.
  logic port_shift, port_load, len_shift, len_load;
  logic data_bit, par_bit, frame_end;

  logic              ser_out_q;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic              done_q, port_err_q, parity_err_q;
  logic              port_bad_q;
  logic              par_q;

  assign len_ext   = CNT_W'(len_q);
  assign data_last = (cnt_q == (len_ext - CNT_W'(1)));

  serial_field_shifter #(.W(PORT_W)) u_port_shift (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (port_shift),
    .load_en_i  (port_load),
    .bit_i      (ser_in),
    .next_o     (port_next),
    .data_o     (port_q)
  );

  serial_field_shifter #(.W(LEN_W)) u_len_shift (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (len_shift),
    .load_en_i  (len_load),
    .bit_i      (ser_in),
    .next_o     (len_next),
    .data_o     (len_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    port_shift = 1'b0;
    port_load  = 1'b0;
    len_shift  = 1'b0;
    len_load   = 1'b0;
    data_bit   = 1'b0;
    par_bit    = 1'b0;
    frame_end  = 1'b0;
    if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!ser_in) state_d = ST_PORT;
        end
        ST_PORT: begin
          port_shift = 1'b1;
          if (cnt_q == PORT_LAST) begin
            port_load = 1'b1;
            state_d   = ST_LEN;
          end
        end
        ST_LEN: begin
          len_shift = 1'b1;
          if (cnt_q == LEN_LAST) begin
            len_load = 1'b1;
            if (len_next != '0) begin
              state_d = ST_DATA;
            end else if (PARITY_EN) begin
              state_d = ST_PAR;
            end else begin
              state_d   = ST_IDLE;
              frame_end = 1'b1;
            end
          end
        end
        ST_DATA: begin
          data_bit = 1'b1;
          if (data_last) begin
            if (PARITY_EN) begin
              state_d = ST_PAR;
            end else begin
              state_d   = ST_IDLE;
              frame_end = 1'b1;
            end
          end
        end
        ST_PAR: begin
          par_bit   = 1'b1;
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Channel decode: an out-of-range port matches no channel.
  always_comb begin
    valid_d = '0;
    if (data_bit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (port_q == PORT_W'(c)) valid_d[c] = 1'b1;
      end
    end
  end

  // The counter restarts on every state change so each field counts from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clk_en) begin
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q != ST_IDLE) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Pulse registers update every clk so they fall after one cycle even when
  // clk_en stays low; held values only move on qualified strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_out_q    <= 1'b0;
      valid_q      <= '0;
      done_q       <= 1'b0;
      port_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
      port_bad_q   <= 1'b0;
      par_q        <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      done_q       <= frame_end;
      port_err_q   <= frame_end & port_bad_q;
      parity_err_q <= par_bit & (par_q ^ ser_in);
      if (data_bit) ser_out_q <= ser_in;
      if (port_load) port_bad_q <= ({1'b0, port_next} >= NUM_CH_EXT);
      // Running XOR of port, length and payload bits; the parity bit itself
      // is folded in at the check.
      if (clk_en && state_q == ST_IDLE) begin
        par_q <= 1'b0;
      end else if (port_shift || len_shift || data_bit) begin
        par_q <= par_q ^ ser_in;
      end
    end
  end

  assign ser_out       = ser_out_q;
  assign ser_out_valid = valid_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign port_err      = port_err_q;
  assign parity_err    = parity_err_q;

endmodule

// File: tb/tb_serial_demux_ctrl_p.sv
// Bench for serial_demux_ctrl_p. Three instances share clock, reset and
// clk_en: A (4 channels), B (3 channels), C (4 channels with parity).
module tb_serial_demux_ctrl_p;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  int   en_div = 1;
  int   ph = 0;

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      ph = ph + 1;
      clk_en = (en_div <= 1) || ((ph % en_div) == 0);
    end
  end

  // ---------------- DUTs ----------------
  logic       ser_a = 1'b1, ser_b = 1'b1, ser_c = 1'b1;
  logic       so_a, so_b, so_c;
  logic [3:0] v_a, v_c;
  logic [2:0] v_b;
  logic [1:0] p_a, p_b, p_c;
  logic [3:0] l_a, l_b, l_c;
  logic       bsy_a, bsy_b, bsy_c;
  logic       dn_a, dn_b, dn_c;
  logic       pe_a, pe_b, pe_c;
  logic       pa_a, pa_b, pa_c;

  serial_demux_ctrl_p #(.NUM_CH(4), .LEN_W(4), .PARITY_EN(1'b0)) u_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ser_in(ser_a),
    .ser_out(so_a), .ser_out_valid(v_a), .port_q(p_a), .len_q(l_a),
    .busy(bsy_a), .done(dn_a), .port_err(pe_a), .parity_err(pa_a));

  serial_demux_ctrl_p #(.NUM_CH(3), .LEN_W(4), .PARITY_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ser_in(ser_b),
    .ser_out(so_b), .ser_out_valid(v_b), .port_q(p_b), .len_q(l_b),
    .busy(bsy_b), .done(dn_b), .port_err(pe_b), .parity_err(pa_b));

  serial_demux_ctrl_p #(.NUM_CH(4), .LEN_W(4), .PARITY_EN(1'b1)) u_c (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ser_in(ser_c),
    .ser_out(so_c), .ser_out_valid(v_c), .port_q(p_c), .len_q(l_c),
    .busy(bsy_c), .done(dn_c), .port_err(pe_c), .parity_err(pa_c));

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [15:0] exp_c[$];
  logic [15:0] exp_run[$];
  logic [15:0] exp_snap[$];

  int   checks = 0;
  int   failures = 0;
  logic [2:0] snap_sel = 3'b000;
  logic final_chk = 1'b0;
  logic final_seen = 1'b0;
  logic prev_so_a = 1'b0;
  int   run_a = 0;

  function automatic logic [15:0] mk_data(input logic [3:0] m, input logic b);
    return {2'b01, 4'b0, m, 5'b0, b};
  endfunction

  function automatic logic [15:0] mk_done(input logic [1:0] p, input logic [3:0] l,
                                          input logic pe, input logic pa);
    return {2'b10, 4'b0, p, l, 2'b0, pe, pa};
  endfunction

  function automatic logic [15:0] st_word(input logic bsy, input logic dn, input logic so,
                                          input logic [3:0] v, input logic [1:0] p,
                                          input logic [3:0] l, input logic pe, input logic pa);
    return {1'b0, bsy, dn, so, v, p, l, pe, pa};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int inst, input logic b);
    case (inst)
      0: ser_a = b;
      1: ser_b = b;
      default: ser_c = b;
    endcase
  endtask

  // Sends n bits, bits[n-1] first, one per clk_en edge; returns 1 time unit
  // after the edge that consumed the last bit.
  task automatic send(input int inst, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drive(inst, bits[i]);
      do @(posedge clk); while (clk_en !== 1'b1);
      #1;
    end
    drive(inst, 1'b1);
  endtask

  task automatic push_data(input int inst, input logic [3:0] m, input logic b);
    case (inst)
      0: exp_a.push_back(mk_data(m, b));
      1: exp_b.push_back(mk_data(m, b));
      default: exp_c.push_back(mk_data(m, b));
    endcase
  endtask

  task automatic push_done(input int inst, input logic [1:0] p, input logic [3:0] l,
                           input logic pe, input logic pa);
    case (inst)
      0: exp_a.push_back(mk_done(p, l, pe, pa));
      1: exp_b.push_back(mk_done(p, l, pe, pa));
      default: exp_c.push_back(mk_done(p, l, pe, pa));
    endcase
  endtask

  // Requests a one-cycle status snapshot of the selected instances at the
  // next falling edge.
  task automatic snap(input logic [2:0] sel);
    snap_sel = sel;
    @(negedge clk);
    #1;
    snap_sel = 3'b000;
  endtask

  // Frame 0 10 0011 101 on A: port 2, len 3, payload 1,0,1.
  task automatic frame_a_basic();
    push_data(0, 4'b0100, 1'b1);
    push_data(0, 4'b0100, 1'b0);
    push_data(0, 4'b0100, 1'b1);
    push_done(0, 2'd2, 4'd3, 1'b0, 1'b0);
    exp_run.push_back(16'(9 * en_div));
    send(0, 32'h11D, 10);
  endtask

  // ---------------- monitor ----------------
  task automatic report(input string nm, input logic [15:0] got,
                        input bit have, input logic [15:0] e);
    checks = checks + 1;
    if (!have) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=none", nm, got);
    end else if (got !== e) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", nm, got, e);
    end
  endtask

  task automatic chk_evt(input int inst, input logic [15:0] got);
    logic [15:0] e;
    bit have;
    string nm;
    e = '0;
    have = 1'b0;
    case (inst)
      0: begin nm = "evt_a"; if (exp_a.size() > 0) begin have = 1'b1; e = exp_a.pop_front(); end end
      1: begin nm = "evt_b"; if (exp_b.size() > 0) begin have = 1'b1; e = exp_b.pop_front(); end end
      default: begin nm = "evt_c"; if (exp_c.size() > 0) begin have = 1'b1; e = exp_c.pop_front(); end end
    endcase
    report(nm, got, have, e);
  endtask

  task automatic chk_snap(input string nm, input logic [15:0] got);
    logic [15:0] e;
    bit have;
    e = '0;
    have = 1'b0;
    if (exp_snap.size() > 0) begin have = 1'b1; e = exp_snap.pop_front(); end
    report(nm, got, have, e);
  endtask

  task automatic chk_empty(input string nm, input int sz);
    checks = checks + 1;
    if (sz != 0) begin
      failures = failures + 1;
      $display("FAIL %s leftover=%0d exp=0", nm, sz);
    end
  endtask

  always @(negedge clk) begin
    // Output events: payload pulses and frame-end pulses.
    if (v_a != 4'b0) chk_evt(0, mk_data(v_a, so_a));
    if (dn_a) chk_evt(0, mk_done(p_a, l_a, pe_a, pa_a));
    if ((pe_a || pa_a) && !dn_a) chk_evt(0, {2'b11, 12'b0, pe_a, pa_a});
    if (v_b != 3'b0) chk_evt(1, mk_data({1'b0, v_b}, so_b));
    if (dn_b) chk_evt(1, mk_done(p_b, l_b, pe_b, pa_b));
    if ((pe_b || pa_b) && !dn_b) chk_evt(1, {2'b11, 12'b0, pe_b, pa_b});
    if (v_c != 4'b0) chk_evt(2, mk_data(v_c, so_c));
    if (dn_c) chk_evt(2, mk_done(p_c, l_c, pe_c, pa_c));
    if ((pe_c || pa_c) && !dn_c) chk_evt(2, {2'b11, 12'b0, pe_c, pa_c});

    // ser_out may only move together with a valid pulse (or under reset).
    if (!rst && v_a == 4'b0 && so_a !== prev_so_a) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL hold_a ser_out=%b exp=%b", so_a, prev_so_a);
    end
    prev_so_a = so_a;

    // Length of each busy stretch on A.
    if (bsy_a === 1'b1) begin
      run_a = run_a + 1;
    end else if (run_a != 0) begin
      logic [15:0] e;
      bit have;
      e = '0;
      have = 1'b0;
      if (exp_run.size() > 0) begin have = 1'b1; e = exp_run.pop_front(); end
      report("busy_run_a", 16'(run_a), have, e);
      run_a = 0;
    end

    if (snap_sel[0]) chk_snap("snap_a", st_word(bsy_a, dn_a, so_a, v_a, p_a, l_a, pe_a, pa_a));
    if (snap_sel[1]) chk_snap("snap_b", st_word(bsy_b, dn_b, so_b, {1'b0, v_b}, p_b, l_b, pe_b, pa_b));
    if (snap_sel[2]) chk_snap("snap_c", st_word(bsy_c, dn_c, so_c, v_c, p_c, l_c, pe_c, pa_c));

    if (final_chk && !final_seen) begin
      final_seen = 1'b1;
      chk_empty("drain_a", exp_a.size());
      chk_empty("drain_b", exp_b.size());
      chk_empty("drain_c", exp_c.size());
      chk_empty("drain_run", exp_run.size());
      chk_empty("drain_snap", exp_snap.size());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state of all three instances.
    repeat (2) @(posedge clk);
    #1;
    repeat (3) exp_snap.push_back(16'h0000);
    snap(3'b111);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // A: basic frame.
    frame_a_basic();
    repeat (3) @(posedge clk);
    #1;

    // A: zero-length frame, done one cycle after the last length bit,
    // then a back-to-back frame starting on the very next edge.
    push_done(0, 2'd0, 4'd0, 1'b0, 1'b0);
    exp_run.push_back(16'd6);
    send(0, 32'h000, 7);
    exp_snap.push_back(st_word(1'b0, 1'b1, 1'b1, 4'b0, 2'd0, 4'd0, 1'b0, 1'b0));
    snap(3'b001);
    push_data(0, 4'b0010, 1'b1);
    push_data(0, 4'b0010, 1'b1);
    push_done(0, 2'd1, 4'd2, 1'b0, 1'b0);
    exp_run.push_back(16'd8);
    send(0, 32'h04B, 9);
    repeat (3) @(posedge clk);
    #1;

    // B (3 channels): port 3 is out of range, then a normal frame.
    push_done(1, 2'd3, 4'd2, 1'b1, 1'b0);
    send(1, 32'h0CA, 9);
    push_data(1, 4'b0100, 1'b1);
    push_done(1, 2'd2, 4'd1, 1'b0, 1'b0);
    send(1, 32'h043, 8);
    repeat (3) @(posedge clk);
    #1;

    // C (parity): good parity, bad parity, zero length with parity.
    push_data(2, 4'b0010, 1'b1);
    push_done(2, 2'd1, 4'd1, 1'b0, 1'b0);
    send(2, 32'h047, 9);
    push_data(2, 4'b0010, 1'b1);
    push_done(2, 2'd1, 4'd1, 1'b0, 1'b1);
    send(2, 32'h046, 9);
    push_done(2, 2'd0, 4'd0, 1'b0, 1'b0);
    send(2, 32'h000, 8);
    repeat (3) @(posedge clk);
    #1;

    // A: clk_en one cycle in four.
    en_div = 4;
    frame_a_basic();
    en_div = 1;
    repeat (4) @(posedge clk);
    #1;

    // A: reset in the middle of the payload (port 3, len 5, two bits sent).
    push_data(0, 4'b1000, 1'b1);
    push_data(0, 4'b1000, 1'b0);
    exp_run.push_back(16'd9);
    send(0, 32'h0D6, 9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_snap.push_back(16'h0000);
    snap(3'b001);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // A: normal frame after the abort.
    frame_a_basic();
    repeat (5) @(negedge clk);
    final_chk = 1'b1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_demux_ctrl_p.md
Name: serial_demux_ctrl_p

Overview:
Parametrised next-generation frame controller for the multi-channel serial transmitter. It watches a single serial line for a start bit, then captures a port field and a length field. It forwards the payload bits to one of NUM_CH channels with per-channel valid qualifiers. Unlike the fixed 4-channel controller, it adds zero-length frames, invalid-port detection, optional even parity, and registered field outputs.

Parameters:
NUM_CH, 4, number of output channels (>=2); PORT_W = max(1, clog2(NUM_CH)) is a derived localparam.
LEN_W, 4, length field width; payload length is 0..2^LEN_W-1 bits.
PARITY_EN, 0, 1 = one even-parity bit follows the payload.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clk_en  in  1  bit strobe; the FSM, counters and shifters advance only on clk edges with clk_en=1
ser_in  in  1  serial line, idle high
ser_out  out  1  registered copy of the current payload bit
ser_out_valid  out  NUM_CH  one-hot qualifier for ser_out
port_q  out  PORT_W  captured port field, held until the next frame's port field completes
len_q  out  LEN_W  captured length field, held likewise
busy  out  1  high in every state except IDLE
done  out  1  1-clk pulse at frame end
port_err  out  1  1-clk pulse with done when port_q >= NUM_CH
parity_err  out  1  1-clk pulse with done on parity mismatch (always 0 when PARITY_EN=0)

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE; every output and internal counter/shifter = 0. Reset overrides clk_en and aborts any frame mid-flight with no done pulse.
- States: IDLE, PORT, LEN, DATA, PAR. Each "bit" below is one clk edge with clk_en=1.
- IDLE: ser_in=0 → PORT with the bit counter cleared; ser_in=1 → stay in IDLE.
- PORT: shift PORT_W bits, MSB first. On the last bit, load port_q and go to LEN.
- LEN: shift LEN_W bits, MSB first. On the last bit, load len_q. Next state:
  - len≠0 → DATA;
  - len=0 and PARITY_EN → PAR;
  - len=0 and no parity → IDLE, with done (and port_err if applicable).
- DATA: consume exactly len bits.
  - On each bit, register ser_out=ser_in.
  - ser_out_valid[port_q]=1 for exactly one clk cycle after that edge. If port_q>=NUM_CH, ser_out_valid stays all-zero.
  - After the len-th bit: PARITY_EN → PAR; otherwise → IDLE with done.
- PAR: consume one bit → IDLE with done. parity_err=1 if the XOR of all port, length, payload and parity bits is 1.
- ser_out holds its last value between bits. ser_out_valid, done and the error flags are single-clk pulses regardless of the clk_en duty cycle.
- done is asserted in the clk cycle following the edge that consumes the final frame bit. Back-to-back frames are legal: a start bit may arrive on the very next clk_en edge after the final bit.
- Frame length in bits = 1 + PORT_W + LEN_W + len + PARITY_EN.
- Bit counter width = clog2(max(PORT_W, LEN_W, 2^LEN_W-1)+1). It is cleared on every state entry and never wraps within a field.
- Start detection happens only in IDLE. A low ser_in in any other state is treated as data.
- clk_en=0 freezes state, counters and held outputs; pulses still deassert after one clk.

Decomposition:
- Package sdm_pkg:
  - state encoding constants (IDLE=0, PORT=1, LEN=2, DATA=3, PAR=4, 3-bit);
  - clog2 function;
  - a max function used in the counter-width derivation.
- One sub-module: serial_field_shifter, a parametrised MSB-first shift register with a shift enable and a parallel output. It is instantiated twice, for the port and length fields.

Test Plan:
- NUM_CH=4, LEN_W=4, clk_en=1. Frame bits 0,1,0,0,0,1,1,1,0,1 (port 2, len 3, payload 101) → ser_out_valid=4'b0100 on 3 consecutive cycles, ser_out=1,0,1, port_q=2, len_q=3, then a done pulse; busy high for 9 cycles.
- NUM_CH=3: frame with port=3, len=2 → ser_out_valid stays 0, done and port_err pulse together, and the next frame is decoded normally.
- PARITY_EN=1: port 1, len 1, payload 1, parity bit 1 → done with parity_err=0. Flip the parity bit to 0 → parity_err=1.
- Length 0, no parity: port 0, len 0 → done exactly 1 cycle after the last length bit, with no valid pulses. A back-to-back start bit on the next edge is accepted.
- clk_en asserted 1 cycle in 4 → identical decoded bits, each valid/done pulse lasts exactly 1 clk, and outputs hold in between.
- rst=1 asserted mid-DATA → the next clk gives state IDLE, all outputs 0, and no done. A new frame afterwards decodes correctly.
